// File: rtl/lu_result_cache.sv
// Small address-indexed cache for XOR logic unit results.
// Each entry carries its own valid bit. The registered read port returns
// hit/miss plus the stored data one cycle after the request. A write and a
// read of the same entry on one edge bypass the write data to the reader.
module lu_result_cache #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [ADDR_W:0]  count_q, count_d;
  logic             rdValid_q;
  logic             rdHit_q, rdHit_d;
  logic [WIDTH-1:0] rdData_q, rdData_d;
  logic             wrAccept;

  // Writes are refused while an invalidate is pending or reset is held
  assign in_ready = ~clr & ~reset;
  assign wrAccept = in_valid & in_ready;

  // Next-state for the entry count and the read response
  always_comb begin
    count_d  = count_q;
    rdHit_d  = rdHit_q;
    rdData_d = rdData_q;

    if (clr) begin
      count_d = '0;
    end else if (wrAccept && !valid_q[in_addr]) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end

    if (rd_en) begin
      if (clr) begin
        rdHit_d  = 1'b0;
        rdData_d = '0;
      end else if (wrAccept && (in_addr == rd_addr)) begin
        rdHit_d  = 1'b1;
        rdData_d = in_data;
      end else begin
        rdHit_d  = valid_q[rd_addr];
        rdData_d = valid_q[rd_addr] ? mem_q[rd_addr] : '0;
      end
    end
  end

  // Entry storage: data and valid bits; clr drops valid bits only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr) begin
      valid_q <= '0;
    end else if (wrAccept) begin
      valid_q[in_addr] <= 1'b1;
      mem_q[in_addr]   <= in_data;
    end
  end

  // Occupancy counter and registered read response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      rdValid_q <= 1'b0;
      rdHit_q   <= 1'b0;
      rdData_q  <= '0;
    end else begin
      count_q   <= count_d;
      rdValid_q <= rd_en;
      rdHit_q   <= rdHit_d;
      rdData_q  <= rdData_d;
    end
  end

  assign count    = count_q;
  assign rd_valid = rdValid_q;
  assign rd_hit   = rdHit_q;
  assign rd_data  = rdData_q;

endmodule
